// File: rtl/nn_ram_sequencer.sv
// Purpose : loads receiver packets into the shared data RAM, then lends the RAM port to the CPU for one inference run.
// Latency : RAM writes are combinational from rx/cpu strobes; the CPU gets the port the cycle after the last packet word.
// Backpressure: rx_ready is low outside LOAD, so the receiver stalls with no data lost; CPU stores are dropped while not owner.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   rx_valid/rx_data/rx_ready       - receiver word stream (transfer = valid & ready)
//   cpu_we/cpu_addr/cpu_wdata       - CPU external memory request
//   cpu_rdata                       - RAM read data to CPU, forced to 0 when the CPU is not owner
//   cpu_halt                        - CPU halt status
//   receive_done                    - level request releasing the CPU from halt
//   ram_we/ram_addr/ram_wdata       - single-port RAM request
//   ram_rdata                       - RAM read data (1-cycle synchronous read)
//   owner_cpu                       - 1 while the CPU owns the RAM port
//   pkt_count                       - completed inference runs (wraps)
//   err                             - sticky: bit0 CPU store while not owner, bit1 release timeout
module nn_ram_sequencer #(
    parameter int DATA_AW   = 14,
    parameter int DW        = 24,
    parameter int PKT_WORDS = 196,
    parameter int X_BASE    = 0,
    parameter int REL_TMO   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_valid,
    input  logic [DW-1:0]      rx_data,
    output logic               rx_ready,
    input  logic               cpu_we,
    input  logic [DATA_AW-1:0] cpu_addr,
    input  logic [DW-1:0]      cpu_wdata,
    output logic [DW-1:0]      cpu_rdata,
    input  logic               cpu_halt,
    output logic               receive_done,
    output logic               ram_we,
    output logic [DATA_AW-1:0] ram_addr,
    output logic [DW-1:0]      ram_wdata,
    input  logic [DW-1:0]      ram_rdata,
    output logic               owner_cpu,
    output logic [15:0]        pkt_count,
    output logic [1:0]         err
);

    typedef enum logic [1:0] {
        S_LOAD      = 2'd0,
        S_RELEASE   = 2'd1,
        S_RUN       = 2'd2,
        S_WAIT_HALT = 2'd3
    } state_t;

    localparam int RW = (REL_TMO < 2) ? 1 : $clog2(REL_TMO + 1);

    // Base address folded into the RAM address space so X_BASE+idx wraps naturally.
    localparam logic [DATA_AW-1:0] XB       = DATA_AW'(X_BASE);
    localparam logic [DATA_AW-1:0] IDX_LAST = DATA_AW'(PKT_WORDS - 1);
    localparam logic [RW-1:0]      REL_LAST = RW'(REL_TMO - 1);

    state_t             state, state_nxt;
    logic [DATA_AW-1:0] idx, idx_nxt;
    logic [RW-1:0]      rel_cnt, rel_nxt;
    logic [15:0]        pkt_nxt;
    logic [1:0]         err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            idx       <= '0;
            rel_cnt   <= '0;
            pkt_count <= '0;
            err       <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            rel_cnt   <= rel_nxt;
            pkt_count <= pkt_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        rel_nxt      = rel_cnt;
        pkt_nxt      = pkt_count;
        err_nxt      = err;
        rx_ready     = 1'b0;
        receive_done = 1'b0;
        owner_cpu    = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = cpu_addr;
        ram_wdata    = cpu_wdata;
        cpu_rdata    = '0;

        case (state)
            S_LOAD: begin
                // The receiver owns the port; CPU traffic is blocked and flagged.
                rx_ready  = 1'b1;
                ram_we    = rx_valid;
                ram_addr  = XB + idx;
                ram_wdata = rx_data;
                if (cpu_we) begin
                    err_nxt[0] = 1'b1;
                end
                if (rx_valid) begin
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        rel_nxt   = '0;
                        state_nxt = S_RELEASE;
                    end else begin
                        idx_nxt = idx + DATA_AW'(1);
                    end
                end
            end

            S_RELEASE: begin
                // CPU already owns the port so its first fetch after leaving halt is served.
                receive_done = 1'b1;
                owner_cpu    = 1'b1;
                ram_we       = cpu_we;
                cpu_rdata    = ram_rdata;
                if (!cpu_halt) begin
                    state_nxt = S_RUN;
                end else if (rel_cnt == REL_LAST) begin
                    // CPU never responded: take the RAM back and wait for a fresh packet.
                    err_nxt[1] = 1'b1;
                    state_nxt  = S_LOAD;
                end else begin
                    rel_nxt = rel_cnt + RW'(1);
                end
            end

            S_RUN: begin
                owner_cpu = 1'b1;
                ram_we    = cpu_we;
                cpu_rdata = ram_rdata;
                if (cpu_halt) begin
                    state_nxt = S_WAIT_HALT;
                end
            end

            S_WAIT_HALT: begin
                // Keep the CPU as owner one more cycle so the read issued alongside
                // halt still returns data; ownership drops on entry to LOAD.
                owner_cpu = 1'b1;
                ram_we    = cpu_we;
                cpu_rdata = ram_rdata;
                pkt_nxt   = pkt_count + 16'd1;
                state_nxt = S_LOAD;
            end

            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_nn_ram_sequencer.sv
module tb_nn_ram_sequencer;

    localparam int AW = 14;
    localparam int DW = 24;

    logic          clk;
    logic          rst_n;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_ready;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_halt;
    logic          receive_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          owner_cpu;
    logic [15:0]   pkt_count;
    logic [1:0]    err;

    int checks = 0;
    int errors = 0;

    nn_ram_sequencer #(
        .DATA_AW(AW), .DW(DW), .PKT_WORDS(4), .X_BASE(0), .REL_TMO(15)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt),
        .receive_done(receive_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .owner_cpu(owner_cpu), .pkt_count(pkt_count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, read-before-write, 1-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rxv;
        logic [DW-1:0] rxd;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          halt;
        logic          e_rdy;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic          e_done;
        logic          e_own;
        logic [DW-1:0] e_rdata;
        logic [15:0]   e_pkt;
        logic [1:0]    e_err;
    } vec_t;

    vec_t vt [15];

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic h);
        rx_valid  = v;
        rx_data   = d;
        cpu_we    = w;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_halt  = h;
    endtask

    // Streams n packet words base+1..base+n, one per cycle, with halt held high.
    task automatic load_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b1, base + DW'(i + 1), 1'b0, '0, '0, 1'b1);
            #1;
            chk("load_rx_ready", 32'(rx_ready), 32'd1);
            chk("load_ram_we", 32'(ram_we), 32'd1);
            chk("load_ram_addr", 32'(ram_addr), 32'(i));
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        int cnt;

        // Main packet + inference run, one record per cycle.
        //          rxv   rxd          we    addr      wd           halt | rdy   we    addr      done  own   rdata        pkt    err
        vt[0]  = '{1'b1, 24'hA00001, 1'b0, 14'h000, 24'h000000, 1'b1, 1'b1, 1'b1, 14'h000, 1'b0, 1'b0, 24'h000000, 16'd0, 2'b00};
        vt[1]  = '{1'b1, 24'hA00002, 1'b0, 14'h000, 24'h000000, 1'b1, 1'b1, 1'b1, 14'h001, 1'b0, 1'b0, 24'h000000, 16'd0, 2'b00};
        vt[2]  = '{1'b1, 24'hA00003, 1'b0, 14'h000, 24'h000000, 1'b1, 1'b1, 1'b1, 14'h002, 1'b0, 1'b0, 24'h000000, 16'd0, 2'b00};
        vt[3]  = '{1'b1, 24'hA00004, 1'b0, 14'h000, 24'h000000, 1'b1, 1'b1, 1'b1, 14'h003, 1'b0, 1'b0, 24'h000000, 16'd0, 2'b00};
        vt[4]  = '{1'b1, 24'hA0BEEF, 1'b0, 14'h000, 24'h000000, 1'b1, 1'b0, 1'b0, 14'h000, 1'b1, 1'b1, 24'h000000, 16'd0, 2'b00};
        vt[5]  = '{1'b1, 24'hA0BEEF, 1'b0, 14'h000, 24'h000000, 1'b1, 1'b0, 1'b0, 14'h000, 1'b1, 1'b1, 24'hA00001, 16'd0, 2'b00};
        vt[6]  = '{1'b1, 24'hA0BEEF, 1'b0, 14'h001, 24'h000000, 1'b0, 1'b0, 1'b0, 14'h001, 1'b1, 1'b1, 24'hA00001, 16'd0, 2'b00};
        vt[7]  = '{1'b1, 24'hA0BEEF, 1'b0, 14'h002, 24'h000000, 1'b0, 1'b0, 1'b0, 14'h002, 1'b0, 1'b1, 24'hA00002, 16'd0, 2'b00};
        vt[8]  = '{1'b1, 24'hA0BEEF, 1'b1, 14'h100, 24'h123456, 1'b0, 1'b0, 1'b1, 14'h100, 1'b0, 1'b1, 24'hA00003, 16'd0, 2'b00};
        vt[9]  = '{1'b0, 24'h000000, 1'b0, 14'h100, 24'h000000, 1'b0, 1'b0, 1'b0, 14'h100, 1'b0, 1'b1, 24'h000000, 16'd0, 2'b00};
        vt[10] = '{1'b0, 24'h000000, 1'b0, 14'h003, 24'h000000, 1'b0, 1'b0, 1'b0, 14'h003, 1'b0, 1'b1, 24'h123456, 16'd0, 2'b00};
        vt[11] = '{1'b0, 24'h000000, 1'b1, 14'h101, 24'h654321, 1'b1, 1'b0, 1'b1, 14'h101, 1'b0, 1'b1, 24'hA00004, 16'd0, 2'b00};
        vt[12] = '{1'b0, 24'h000000, 1'b0, 14'h101, 24'h000000, 1'b1, 1'b0, 1'b0, 14'h101, 1'b0, 1'b1, 24'h000000, 16'd0, 2'b00};
        vt[13] = '{1'b0, 24'h000000, 1'b1, 14'h000, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 14'h000, 1'b0, 1'b0, 24'h000000, 16'd1, 2'b00};
        vt[14] = '{1'b0, 24'h000000, 1'b0, 14'h000, 24'h000000, 1'b1, 1'b1, 1'b0, 14'h000, 1'b0, 1'b0, 24'h000000, 16'd1, 2'b01};

        // Reset state.
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        #12;
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_done", 32'(receive_done), 32'd0);
        chk("rst_owner", 32'(owner_cpu), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vt[i].rxv, vt[i].rxd, vt[i].we, vt[i].addr, vt[i].wd, vt[i].halt);
            #1;
            chk($sformatf("v%0d_rx_ready", i), 32'(rx_ready), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vt[i].e_we));
            chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vt[i].e_addr));
            chk($sformatf("v%0d_done", i), 32'(receive_done), 32'(vt[i].e_done));
            chk($sformatf("v%0d_owner", i), 32'(owner_cpu), 32'(vt[i].e_own));
            chk($sformatf("v%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(vt[i].e_rdata));
            chk($sformatf("v%0d_pkt", i), 32'(pkt_count), 32'(vt[i].e_pkt));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].e_err));
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        chk("mem0_after_blocked_store", 32'(mem[0]), 32'hA00001);
        chk("mem1", 32'(mem[1]), 32'hA00002);
        chk("mem2", 32'(mem[2]), 32'hA00003);
        chk("mem3", 32'(mem[3]), 32'hA00004);
        chk("mem100_cpu_store", 32'(mem[14'h100]), 32'h123456);
        chk("mem101_store_with_halt", 32'(mem[14'h101]), 32'h654321);

        // Release timeout: halt never drops.
        load_words(24'hB00000, 4);
        #1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (!receive_done) break;
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("tmo_done_cycles", 32'(cnt), 32'd15);
        chk("tmo_err", 32'(err), 32'd3);
        chk("tmo_rx_ready", 32'(rx_ready), 32'd1);
        chk("tmo_owner", 32'(owner_cpu), 32'd0);
        chk("tmo_pkt", 32'(pkt_count), 32'd1);
        chk("tmo_mem0", 32'(mem[0]), 32'hB00001);
        chk("tmo_mem3", 32'(mem[3]), 32'hB00004);

        // Asynchronous reset after 2 of 4 words.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 24'hC00001 + DW'(i), 1'b0, '0, '0, 1'b1);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rx_ready", 32'(rx_ready), 32'd1);
        chk("arst_done", 32'(receive_done), 32'd0);
        chk("arst_owner", 32'(owner_cpu), 32'd0);
        chk("arst_ram_addr", 32'(ram_addr), 32'd0);
        chk("arst_pkt", 32'(pkt_count), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_words(24'hD00000, 4);
        #1;
        chk("fresh_done", 32'(receive_done), 32'd1);
        chk("fresh_owner", 32'(owner_cpu), 32'd1);
        chk("fresh_mem0", 32'(mem[0]), 32'hD00001);
        chk("fresh_mem1", 32'(mem[1]), 32'hD00002);
        chk("fresh_mem2", 32'(mem[2]), 32'hD00003);
        chk("fresh_mem3", 32'(mem[3]), 32'hD00004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
